// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap entry/exit sequencer and trap CSR file.
//
// Takes an interrupt request from the interrupt controller, holds it until
// the next instruction boundary, then saves mepc/mcause, updates mstatus and
// redirects fetch to mtvec. Executing mret restores mstatus and redirects
// fetch back to mepc.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   trap_entry_en_i   interrupt request (pulse or level)
//   int_index_i       interrupt number, valid with trap_entry_en_i
//   trap_exit_en_i    mret executing
//   instr_retire_i    instruction boundary this cycle
//   pc_next_i         PC of next instruction, valid with instr_retire_i
//   csr_we_i/addr_i/wdata_i, csr_rdata_o   CSR port (read is combinational)
//   int_mstatus_mie_o mstatus.MIE to the interrupt controller
//   mret_en_o         one-cycle pulse when the mret restore completes
//   redirect_en_o     one-cycle fetch redirect strobe
//   redirect_pc_o     redirect target, valid with redirect_en_o
//   pipe_hold_o       stall fetch/issue during ENTER/EXIT
//   in_trap_o         handler active
module trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_entry_en_i,
  input  logic [3:0]      int_index_i,
  input  logic            trap_exit_en_i,
  input  logic            instr_retire_i,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            int_mstatus_mie_o,
  output logic            mret_en_o,
  output logic            redirect_en_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            pipe_hold_o,
  output logic            in_trap_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_DROPCNT = 12'h7C0;

  // Clears the two low bits of a PC/mepc value.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  typedef enum logic [2:0] {
    S_IDLE, S_PEND, S_ENTER, S_HANDLER, S_EXIT
  } state_e;

  state_e          state_q;
  logic [3:0]      idx_q;
  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mtvec_q, mepc_q;
  logic            mcause_irq_q;
  logic [3:0]      mcause_code_q;
  logic [7:0]      drop_cnt_q;
  logic            redirect_en_q, mret_en_q, pipe_hold_q, in_trap_q;
  logic [XLEN-1:0] redirect_pc_q;

  // Post-write views of mtvec/mepc so a redirect computed in the same cycle
  // as a software write targets the value the CSR is about to hold.
  logic [XLEN-1:0] mtvec_d, mepc_d, trap_pc_d;
  logic            drop_d;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    mtvec_d = mtvec_q;
    mepc_d  = mepc_q;
    if (csr_we_i && csr_addr_i == ADDR_MTVEC) mtvec_d = csr_wdata_i;
    if (csr_we_i && csr_addr_i == ADDR_MEPC)  mepc_d  = csr_wdata_i & ALIGN_MASK;

    trap_pc_d = mtvec_d & ALIGN_MASK;
    if (VECTORED_EN && mtvec_d[1:0] == 2'b01)
      trap_pc_d = trap_pc_d + {{(XLEN-6){1'b0}}, idx_q, 2'b00};

    // In IDLE a request is only lost when mret wins the same cycle; in every
    // other state any request is a drop (level source held high).
    drop_d = trap_entry_en_i && (state_q != S_IDLE || trap_exit_en_i);
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[3] = mie_q;
        csr_rdata_o[7] = mpie_q;
      end
      ADDR_MTVEC:   csr_rdata_o = mtvec_q;
      ADDR_MEPC:    csr_rdata_o = mepc_q;
      ADDR_MCAUSE: begin
        csr_rdata_o[XLEN-1] = mcause_irq_q;
        csr_rdata_o[3:0]    = mcause_code_q;
      end
      ADDR_DROPCNT: csr_rdata_o = {{(XLEN-8){1'b0}}, drop_cnt_q};
      default:      csr_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= RESET_MTVEC;
      mepc_q        <= '0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= '0;
      drop_cnt_q    <= '0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= '0;
      mret_en_q     <= 1'b0;
      pipe_hold_q   <= 1'b0;
      in_trap_q     <= 1'b0;
    end else begin
      redirect_en_q <= 1'b0;
      mret_en_q     <= 1'b0;
      pipe_hold_q   <= 1'b0;

      // NOTE: non-blocking assignments to the same register resolve to the
      // last one executed, so the FSM updates below deliberately override
      // any software CSR write made in the same cycle.
      if (csr_we_i) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mie_q  <= csr_wdata_i[3];
            mpie_q <= csr_wdata_i[7];
          end
          ADDR_MTVEC:  mtvec_q <= csr_wdata_i;
          ADDR_MEPC:   mepc_q  <= csr_wdata_i & ALIGN_MASK;
          ADDR_MCAUSE: begin
            mcause_irq_q  <= csr_wdata_i[XLEN-1];
            mcause_code_q <= csr_wdata_i[3:0];
          end
          default: ;
        endcase
      end

      if (drop_d && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (trap_exit_en_i) begin
            state_q       <= S_EXIT;
            redirect_en_q <= 1'b1;
            mret_en_q     <= 1'b1;
            pipe_hold_q   <= 1'b1;
            redirect_pc_q <= mepc_d;
          end else if (trap_entry_en_i) begin
            idx_q   <= int_index_i;
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          if (instr_retire_i) begin
            mepc_q        <= pc_next_i & ALIGN_MASK;
            state_q       <= S_ENTER;
            redirect_en_q <= 1'b1;
            pipe_hold_q   <= 1'b1;
            redirect_pc_q <= trap_pc_d;
          end
        end
        S_ENTER: begin
          mcause_irq_q  <= 1'b1;
          mcause_code_q <= idx_q;
          mpie_q        <= mie_q;
          mie_q         <= 1'b0;
          state_q       <= S_HANDLER;
          in_trap_q     <= 1'b1;
        end
        S_HANDLER: begin
          if (trap_exit_en_i) begin
            state_q       <= S_EXIT;
            in_trap_q     <= 1'b0;
            redirect_en_q <= 1'b1;
            mret_en_q     <= 1'b1;
            pipe_hold_q   <= 1'b1;
            redirect_pc_q <= mepc_d;
          end
        end
        S_EXIT: begin
          mie_q   <= mpie_q;
          mpie_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign int_mstatus_mie_o = mie_q;
  assign mret_en_o         = mret_en_q;
  assign redirect_en_o     = redirect_en_q;
  assign redirect_pc_o     = redirect_pc_q;
  assign pipe_hold_o       = pipe_hold_q;
  assign in_trap_o         = in_trap_q;

endmodule
